// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the pipeline-side request/response signals and
// the unified-memory signals of mem_port_arbiter.
//
// Handshake: a requester raises req with stable fields and holds it until the
// one-cycle ready pulse; rdata is valid in the ready cycle and holds until the
// next completion of that port. The memory sees a one-cycle mem_en strobe
// (mem_we qualified by mem_en) and returns mem_rdata MEM_LAT cycles later.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic [DATA_W-1:0]     if_rdata;
    logic                  if_ready;
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_be;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_ready;
    logic                  stall_if;
    logic                  stall_mem;
    logic                  mem_en;
    logic                  mem_we;
    logic [DATA_W/8-1:0]   mem_be;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;

    // Arbiter view.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
        output if_rdata, if_ready, d_rdata, d_ready, stall_if, stall_mem,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    // Pipeline plus memory view.
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
        input  if_rdata, if_ready, d_rdata, d_ready, stall_if, stall_mem,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port fixed-latency memory between the
// instruction-fetch port and the data port. One access is outstanding at a
// time: IDLE -> ISSUE (mem_en) -> WAIT (MEM_LAT cycles) -> RESP (ready pulse).
// Data has priority over IF. Optional macro ARB_STARVE_GUARD_EN forces an IF
// grant after STARVE_MAX consecutive data grants made while IF was waiting.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus,
    output logic [1:0]          dbg_state
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state;
    logic                owner_d;
    logic [CNT_W-1:0]    cnt;
    logic                mem_en_q;
    logic                mem_we_q;
    logic [BE_W-1:0]     mem_be_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                if_ready_q;
    logic                d_ready_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   d_rdata_q;
    logic                grant_d;
    logic                grant_if;

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_cnt;
    logic          starve_hit;
    assign starve_hit = (starve_cnt == SW'(STARVE_MAX));
`endif

    // Arbitration decision, only acted on while IDLE.
    always_comb begin
        grant_d  = bus.d_req;
        grant_if = bus.if_req & ~bus.d_req;
`ifdef ARB_STARVE_GUARD_EN
        if (bus.if_req && bus.d_req && starve_hit) begin
            grant_d  = 1'b0;
            grant_if = 1'b1;
        end
`endif
    end

    // Access sequencer: latch the winner, strobe the memory, wait, respond.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            owner_d     <= 1'b0;
            cnt         <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d || grant_if) begin
                        owner_d     <= grant_d;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= grant_d & bus.d_we;
                        mem_be_q    <= grant_d ? bus.d_be : {BE_W{1'b1}};
                        mem_addr_q  <= grant_d ? bus.d_addr : bus.if_addr;
                        mem_wdata_q <= grant_d ? bus.d_wdata : '0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en_q <= 1'b0;
                    cnt      <= CNT_W'(MEM_LAT);
                    state    <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        // mem_rdata is valid this cycle; writes keep the old rdata.
                        if (!mem_we_q) begin
                            if (owner_d) d_rdata_q  <= bus.mem_rdata;
                            else         if_rdata_q <= bus.mem_rdata;
                        end
                        if (owner_d) d_ready_q  <= 1'b1;
                        else         if_ready_q <= 1'b1;
                        state <= RESP;
                    end
                end
                RESP: begin
                    if_ready_q <= 1'b0;
                    d_ready_q  <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    // Count data grants that bypassed a waiting IF request; any IF grant clears.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (grant_if)
                starve_cnt <= '0;
            else if (grant_d && bus.if_req && !starve_hit)
                starve_cnt <= starve_cnt + SW'(1);
        end
    end
`endif

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.stall_if  = bus.if_req & ~if_ready_q;
    assign bus.stall_mem = bus.d_req & ~d_ready_q;
    assign dbg_state     = state;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between the pipeline's instruction-fetch (IF) port and data-access (MEM-stage) port.
- Arbitrates between the two ports, sequences each access, captures the read data and returns a one-cycle ready pulse.
- Produces the per-port stall signals the pipeline control uses to freeze stages.
- Sits between the Mips top-level datapath and its memory model.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits; byte enables are DATA_W/8 bits.
- MEM_LAT, 2, cycles from the mem_en cycle to valid mem_rdata; must be >= 1.
- STARVE_MAX, 3, consecutive data grants allowed while if_req waits; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  instruction fetch request; held high until if_ready.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched word, valid when if_ready=1.
- if_ready  out  1  one-cycle completion pulse for IF.
- d_req  in  1  data request; held high until d_ready.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_be  in  DATA_W/8  byte enables.
- d_rdata  out  DATA_W  read data, valid when d_ready=1.
- d_ready  out  1  one-cycle completion pulse for data.
- stall_if  out  1  combinational: if_req & ~if_ready.
- stall_mem  out  1  combinational: d_req & ~d_ready.
- mem_en  out  1  one-cycle memory access strobe.
- mem_we  out  1  write strobe, qualified by mem_en.
- mem_be  out  DATA_W/8  byte enables to memory.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle.

Behaviour:

Reset:
- rst low asynchronously forces IDLE.
- All registered outputs go to 0 (mem_*, if_ready, d_ready, if_rdata, d_rdata).
- The latency counter, the grant register and the starvation counter all clear.
- Reset mid-transaction abandons the access; no ready pulse is issued and a late mem_rdata is ignored.

FSM states: IDLE, ISSUE, WAIT, RESP. All mem_* outputs are registered.
- IDLE: requests are sampled at the clock edge.
  - Only one request high: grant it.
  - Both high: data wins (subject to the optional feature).
  - On a grant: latch owner, address, we, be and wdata, then go to ISSUE.
  - For an IF grant, force mem_we=0 and mem_be=all ones.
- ISSUE: mem_en=1 for exactly one cycle, with the latched fields on mem_*. Load cnt=MEM_LAT, go to WAIT.
- WAIT: mem_en=0 and cnt decrements each cycle.
  - In the cycle cnt==1, mem_rdata is valid. Capture it into the owner's rdata register for reads only; on writes, rdata holds its previous value.
  - Go to RESP.
- RESP: pulse the owner's ready for one cycle, then go to IDLE.

Timing and throughput:
- Request first high in cycle T gives ready in cycle T+MEM_LAT+2.
- Throughput is one access per MEM_LAT+3 cycles. No pipelining; one access is outstanding at a time.
- The requester drops req (or presents its next request) in the cycle after ready. IDLE re-samples at the edge ending that cycle, so the requester completing at R can be re-granted and reach ISSUE at R+2.

Protocol rules:
- Request fields must stay stable while req is high.
- A req withdrawn before ready is a protocol violation; the granted transaction still completes and ready still pulses.
- if_rdata and d_rdata hold their values between completions.
- Stall outputs follow req combinationally, so a stage stalls from its request's first cycle up to, not including, its ready cycle.

Optional Feature:
Macro: ARB_STARVE_GUARD_EN.
- Defined: a starvation counter (width clog2(STARVE_MAX+1)) increments on each data grant made while if_req=1, saturating at STARVE_MAX.
  - When it equals STARVE_MAX and both requests are high in IDLE, IF is granted instead of data.
  - The counter clears on any IF grant.
- Not defined: strict data priority and no counter logic; IF may starve indefinitely.

Test Plan:
- Reset: rst=0 mid-WAIT of a read -> next cycle all outputs 0, state IDLE; a mem_rdata arriving later produces no ready.
- Single IF read, MEM_LAT=2, mem model returns 32'hDEADBEEF at addr 0x0000_0040: if_req at cycle 0 -> mem_en=1, mem_we=0, mem_be=4'hF in cycle 1; if_ready=1 with if_rdata=32'hDEADBEEF in cycle 4; stall_if=1 in cycles 0-3.
- Data write: d_we=1, d_addr=0x100, d_wdata=32'h12345678, d_be=4'b0011 -> one mem_en cycle carrying those exact values; d_ready pulses 4 cycles after the request; d_rdata unchanged.
- Simultaneous if_req and d_req (read) at cycle 0 -> data access issues first (d_ready at cycle 4, stall_if high throughout); IF re-arbitrated at cycle 5, reaches ISSUE at cycle 6, if_ready at cycle 9.
- With ARB_STARVE_GUARD_EN and STARVE_MAX=3: d_req continuously reasserted and if_req held high -> exactly 3 data grants, then the IF grant, then data resumes. Without the macro: IF is never granted while d_req stays high.
